// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: time-multiplexed N-digit common-anode 7-segment driver with tear-free frame latching.
// Define SEVEN_SEG_LZ_BLANK_EN to suppress leading zeros (digit 0 is never suppressed).
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17,
    parameter int IDX_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              nib;
    logic [6:0]              seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign tick = cnt == CNT_W'(REFRESH_DIV - 1);
    assign wrap = tick && idx == IDX_W'(NUM_DIGITS - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) idx <= wrap ? '0 : idx + IDX_W'(1);
        end

    // Display only changes at frame boundaries; a load landing on the wrap edge bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end
            if (wrap) begin
                disp_bcd <= load ? bcd_in : shadow_bcd;
                disp_dp  <= load ? dp_in : shadow_dp;
            end
        end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    assign lz[0] = 1'b0;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
        assign lz[k] = disp_bcd[4*NUM_DIGITS-1:4*k] == '0;
    end
`else
    assign lz = '0;
`endif

    assign nib     = disp_bcd[4*idx +: 4];
    assign seg_nxt = lz[idx] ? 7'b1111111 : decode(nib);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            an  <= '1;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= en ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg <= en ? seg_nxt : 7'b1111111;
            dp  <= en ? ~disp_dp[idx] : 1'b1;
        end
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb_seven_seg_scan_mux: directed and randomized checks of seven_seg_scan_mux against a slot/frame arithmetic model.
// Honours SEVEN_SEG_LZ_BLANK_EN in the reference model.
module tb_seven_seg_scan_mux;
    localparam int N = 4;
    localparam int R = 4;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           load = 1'b0;
    logic [4*N-1:0] bcd_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;

    int             compared = 0;
    int             mismatched = 0;
    int             cyc;
    logic [4*N-1:0] m_bcd, s_bcd;
    logic [N-1:0]   m_dp, s_dp;

    seven_seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .CNT_W(2), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .bcd_in(bcd_in), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [4*N-1:0] b, input int k);
        logic [3:0] d = b[4*k +: 4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (k > 0 && (b >> (4*k)) == 0) return 7'b1111111;
`endif
        return d < 10 ? SEG_TAB[d] : 7'b1111111;
    endfunction

    task automatic model_clear();
        cyc = 0;
        m_bcd = '0;
        s_bcd = '0;
        m_dp = '0;
        s_dp = '0;
    endtask

    // One clock: slot = cyc/R selects the digit, the last cycle of every N*R-cycle frame latches the display.
    task automatic step(input logic e, input logic l, input logic [4*N-1:0] b, input logic [N-1:0] d);
        int i;
        logic [N-1:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        @(negedge clk);
        rst_n = 1'b1;
        en = e;
        load = l;
        bcd_in = b;
        dp_in = d;
        i = (cyc / R) % N;
        e_an = e ? ~(N'(1) << i) : '1;
        e_seg = e ? exp_seg(m_bcd, i) : 7'b1111111;
        e_dp = e ? ~m_dp[i] : 1'b1;
        if (cyc % (R*N) == R*N - 1) begin
            m_bcd = l ? b : s_bcd;
            m_dp = l ? d : s_dp;
        end
        if (l) begin
            s_bcd = b;
            s_dp = d;
        end
        cyc++;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
    endtask

    task automatic hold(input int n, input logic e);
        for (int j = 0; j < n; j++) step(e, 1'b0, bcd_in, dp_in);
    endtask

    task automatic show(input logic [4*N-1:0] b, input logic [N-1:0] d, input int frames);
        step(1'b1, 1'b1, b, d);
        hold(frames * N * R, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        model_clear();

        show(16'h1234, 4'b0000, 2);
        show(16'h9A07, 4'b0100, 2);
        show(16'h0050, 4'b0000, 2);
        show(16'h0000, 4'b0001, 2);
        show(16'h0050, 4'b1000, 2);

        hold(2, 1'b1);
        hold(5, 1'b0);
        hold(N * R, 1'b1);

        show(16'h1234, 4'b0010, 1);
        hold(6, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an", 32'(an), 32'hF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp", 32'(dp), 32'h1);
        model_clear();
        hold(2 * N * R, 1'b1);

        show(16'h1111, 4'b0000, 2);
        while (cyc % (R*N) != R*N - 1) step(1'b1, 1'b0, bcd_in, dp_in);
        step(1'b1, 1'b1, 16'h2222, 4'b0000);
        hold(N * R, 1'b1);
        check("wrap_load_disp", 32'(m_bcd), 32'h2222);

        for (int j = 0; j < 600; j++) begin
            logic [4*N-1:0] b;
            b = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, b, 4'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rnd_arst_an", 32'(an), 32'hF);
                model_clear();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Accepts a packed BCD word plus per-digit decimal points and decodes digits 0-9. Non-decimal codes are blanked.
- Scans one digit per refresh slot, driving active-low anodes, segments and DP.
- Sits between the datapath/counter logic and the board display pins.
- Successor to the single-digit BCD decoder: adds digit count, refresh prescaler, tear-free frame latching and enable.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- REFRESH_DIV, 100000, clk cycles per digit slot (>=1).
- CNT_W, 17, prescaler width; must satisfy 2**CNT_W >= REFRESH_DIV.
- IDX_W, 2, digit index width; must satisfy 2**IDX_W >= NUM_DIGITS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  display enable; 0 blanks all outputs.
- load  in  1  capture bcd_in/dp_in into the shadow register this cycle.
- bcd_in  in  4*NUM_DIGITS  packed BCD; nibble k = digit k; digit 0 = least significant = rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- an  out  NUM_DIGITS  anode select, active-low, registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.

Behaviour:
- Reset (async, rst_n=0):
  - prescaler=0, idx=0.
  - shadow and display registers = all zero.
  - an=all 1s, seg=7'b1111111, dp=1.
  - Outputs go off immediately, including mid-frame.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and runs regardless of en.
  - tick=1 on the cycle prescaler==REFRESH_DIV-1; prescaler wraps to 0 on that cycle.
  - REFRESH_DIV=1 gives tick every cycle.
- Index:
  - On tick, idx increments; idx==NUM_DIGITS-1 wraps to 0 (wrap event).
  - NUM_DIGITS=1: idx stays 0 and every tick is a wrap.
- Shadow: when load=1, shadow <= {bcd_in, dp_in} on that clock edge.
- Display register (tear-free):
  - Updated only on wrap events.
  - If load=1 on the wrap cycle, display takes bcd_in/dp_in directly (new value wins); otherwise it takes shadow.
  - A frame therefore never mixes old and new digits.
- Outputs (registered, 1 cycle after idx/display change):
  - en=1: an = all 1s except an[idx]=0; seg = decode(display nibble idx); dp = ~display_dp[idx].
  - en=0: an=all 1s, seg=7'b1111111, dp=1 from the next edge. Counters keep running.
- Decode table (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10-15 = 1111111
  - A blanked digit still drives its anode low; its DP still follows dp_in.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEVEN_SEG_LZ_BLANK_EN (leading-zero suppression).
- Defined:
  - Digit k (k>=1) is blanked (seg=1111111) when it and every higher digit in the display register equal 0.
  - Digit 0 is never suppressed.
  - A DP set on a suppressed digit is still lit.
  - Suppression is evaluated on the display register, not the shadow.
- Not defined: all zero digits display as 0.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4, en=1; reset, pulse load with bcd_in=16'h1234, dp_in=0 -> all digits show 0 (1000000) until the first wrap. Next frame cycles: an=1110/seg=0011001, 1101/0110000, 1011/0100100, 0111/1111001, with 4 cycles per digit.
- bcd_in=16'h9A07, dp_in=4'b0100 -> digit3 seg=0010000; digit2 seg=1111111 with dp=0; digit1 seg=1000000; digit0 seg=1111000.
- Drop en mid-slot -> next edge an=1111, seg=1111111, dp=1. Raise en -> scanning resumes at the current idx with no restart.
- Assert rst_n=0 mid-frame while showing 0x1234 -> an, seg, dp go off without a clock edge. After release, display shows 0000 and idx restarts at 0.
- Shadow holds 0x1111; pulse load with 0x2222 exactly on the wrap cycle -> the following frame shows 2 on every digit, with no frame of 1s.
- SEVEN_SEG_LZ_BLANK_EN defined:
  - 0x0050 -> digits 3 and 2 blank, digit1=0010010, digit0=1000000.
  - 0x0000 -> only digit0 shows 1000000.
  - Undefined build, 0x0050 -> digits show 0,0,5,0.
